packet_to_axis: RTL and testbench
=================================

# packet_to_axis

Transmit-side packet framer for the cell link. Captures a parallel packet (index plus NUM_DATA_WORDS 32-bit data words) on a strobe and serializes it onto a 32-bit AXI-Stream master toward the Aurora TX core: one header word, then the data words, with TLAST on the final beat. Framing matches what the receive-side checker expects. A one-entry pending buffer allows back-to-back packets without gaps. Drops and completions are reported as strobes and counters.

## Interface
- MAGIC_WIDTH, 16: header magic width; magic occupies the header MSBs.
- MAGIC_START_BIT, 16: header magic LSB position.
- INDEX_WIDTH, 5: packet index width.
- INDEX_START_BIT, 10: index LSB position in header.
- NUM_DATA_WORDS, 1: data words per packet, ≥1.
- COUNT_WIDTH, 16: width of sentCount/dropCount.
- auroraClk  in  1  sole clock.
- auroraReset  in  1  synchronous, active-high reset.
- headerMagic  in  MAGIC_WIDTH  magic inserted in every header; sampled at header load.
- packetStrobe  in  1  one-cycle request to send packetIndex/packetData.
- packetIndex  in  INDEX_WIDTH  index for the request.
- packetData  in  32*NUM_DATA_WORDS  word j = bits [32*j+:32], sent in order j=0 first.
- TVALID  out  1  AXIS valid.
- TREADY  in  1  AXIS ready.
- TLAST  out  1  high on last data beat.
- TDATA  out  32  AXIS data.
- busy  out  1  active or pending packet held.
- sentStrobe  out  1  one-cycle pulse, packet's TLAST beat accepted.
- dropStrobe  out  1  one-cycle pulse, request discarded.
- sentCount  out  COUNT_WIDTH  completed packets, wraps.
- dropCount  out  COUNT_WIDTH  dropped requests, saturates at all-ones.

## Operation
- Elaboration error if INDEX_START_BIT+INDEX_WIDTH-1 > MAGIC_START_BIT-1 or NUM_DATA_WORDS < 1.
- Header word: magic at [MAGIC_START_BIT+:MAGIC_WIDTH], index at [INDEX_START_BIT+:INDEX_WIDTH], all other bits 0.
- Storage: active slot (packet on the wire) and pending slot; each holds index + data + valid.
- States: S_IDLE, S_HEADER, S_DATA; word counter 0..NUM_DATA_WORDS-1.
- S_IDLE: if active valid, load header into TDATA, TVALID=1, go S_HEADER.
- S_HEADER: on TVALID&&TREADY, present data word 0, counter=0, go S_DATA.
- S_DATA: on handshake, if counter < NUM_DATA_WORDS-1 present next word, counter+1; else packet done: pulse sentStrobe, sentCount+1; if pending valid, move pending→active and present its header same edge (stay TVALID=1, go S_HEADER); else TVALID=0, go S_IDLE.
- TLAST=1 only while presenting word NUM_DATA_WORDS-1.
- Request handling on packetStrobe:
  - active empty: capture into active.
  - active full, pending empty (or pending moving to active this edge): capture into pending.
  - both full and no completion this edge: discard, pulse dropStrobe, dropCount+1 (saturating).
- busy = active valid | pending valid.

## Timing
- All outputs registered. Reset values: TVALID=0, TLAST=0, TDATA=0, busy=0, sentStrobe=0, dropStrobe=0, sentCount=0, dropCount=0; both slots invalid; state S_IDLE.
- AXIS rule: once TVALID=1, TDATA/TLAST hold until TREADY sampled high; TVALID never drops mid-packet except by reset.
- Latency: strobe at edge N (idle, empty) → header visible with TVALID=1 after edge N+1; minimum packet = NUM_DATA_WORDS+1 beats.
- Back-to-back: pending packet's header follows previous TLAST beat with zero idle cycles.
- Strobe coincident with final-beat handshake while pending full: pending→active, request→pending, no drop.
- packetStrobe is ignored while auroraReset=1.
- Reset mid-packet: TVALID low the cycle after reset edge, slots cleared, no sentStrobe; a truncated stream at the receiver is accepted (it reports bad size).
- sentCount wraps from all-ones to 0; dropCount sticks at all-ones.

## Test plan
- NUM_DATA_WORDS=1, magic 0xA5A5, strobe index 3 data 0xDEADBEEF, TREADY=1 → beats 0xA5A50C00 (TLAST=0), 0xDEADBEEF (TLAST=1); sentStrobe once, sentCount=1.
- NUM_DATA_WORDS=4, TREADY random 50% → words 0..3 in order, TDATA/TLAST stable during stalls, TLAST only on word 3.
- Three strobes on consecutive cycles with TREADY=0 → first active, second pending, third dropped (dropStrobe once, dropCount=1); release TREADY → two packets back-to-back with no TVALID gap.
- Strobe on same cycle as final-beat handshake with pending full → no drop; three packets sent total.
- Assert auroraReset during beat 2 of 4 → TVALID=0 next cycle, busy=0, counters 0; new strobe afterwards sends a clean packet.
- Preload dropCount near saturation via repeated drops (COUNT_WIDTH=4) → sticks at 15; sentCount 15→0 on next completion.

Source files
------------

// File: rtl/packet_to_axis.sv
// Transmit-side packet framer: captures a parallel packet on a strobe and
// serializes it as one header word plus NUM_DATA_WORDS data words on AXI-Stream.
`timescale 1ns/1ps
module packet_to_axis #(
    parameter int MAGIC_WIDTH     = 16,
    parameter int MAGIC_START_BIT = 16,
    parameter int INDEX_WIDTH     = 5,
    parameter int INDEX_START_BIT = 10,
    parameter int NUM_DATA_WORDS  = 1,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                        auroraClk,
    input  logic                        auroraReset,
    input  logic [MAGIC_WIDTH-1:0]      headerMagic,
    input  logic                        packetStrobe,
    input  logic [INDEX_WIDTH-1:0]      packetIndex,
    input  logic [32*NUM_DATA_WORDS-1:0] packetData,
    output logic                        TVALID,
    input  logic                        TREADY,
    output logic                        TLAST,
    output logic [31:0]                 TDATA,
    output logic                        busy,
    output logic                        sentStrobe,
    output logic                        dropStrobe,
    output logic [COUNT_WIDTH-1:0]      sentCount,
    output logic [COUNT_WIDTH-1:0]      dropCount,
    output logic [1:0]                  dbg_state
);

    localparam int CNT_W = (NUM_DATA_WORDS > 1) ? $clog2(NUM_DATA_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DATA_WORDS - 1);

    generate
        if ((INDEX_START_BIT + INDEX_WIDTH - 1 > MAGIC_START_BIT - 1) || (NUM_DATA_WORDS < 1)) begin : g_param_check
            $error("packet_to_axis: index field overlaps magic, or NUM_DATA_WORDS < 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_DATA   = 2'd2
    } state_t;

    function automatic logic [31:0] make_header(input logic [MAGIC_WIDTH-1:0] magic,
                                                input logic [INDEX_WIDTH-1:0] idx);
        logic [31:0] h;
        h = '0;
        h[MAGIC_START_BIT +: MAGIC_WIDTH] = magic;
        h[INDEX_START_BIT +: INDEX_WIDTH] = idx;
        return h;
    endfunction

    function automatic logic [31:0] word_at(input logic [32*NUM_DATA_WORDS-1:0] data, input int idx);
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < NUM_DATA_WORDS; j++) begin
            if (idx == j) w = data[32*j +: 32];
        end
        return w;
    endfunction

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          tvalid_q, tvalid_d;
    logic                          tlast_q, tlast_d;
    logic [31:0]                   tdata_q, tdata_d;
    logic                          act_valid_q, act_valid_d;
    logic [INDEX_WIDTH-1:0]        act_index_q, act_index_d;
    logic [32*NUM_DATA_WORDS-1:0]  act_data_q, act_data_d;
    logic                          pend_valid_q, pend_valid_d;
    logic [INDEX_WIDTH-1:0]        pend_index_q, pend_index_d;
    logic [32*NUM_DATA_WORDS-1:0]  pend_data_q, pend_data_d;
    logic                          busy_q, busy_d;
    logic                          sent_strobe_q, sent_strobe_d;
    logic                          drop_strobe_q, drop_strobe_d;
    logic [COUNT_WIDTH-1:0]        sent_count_q, sent_count_d;
    logic [COUNT_WIDTH-1:0]        drop_count_q, drop_count_d;
    logic                          hs;
    logic                          done;
    logic                          drop;

    // A beat transfers on a rising edge where TVALID && TREADY; once TVALID is
    // raised, TDATA/TLAST hold until that transfer and TVALID only falls after TLAST.
    assign hs = tvalid_q && TREADY;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (act_valid_q) begin
                    tdata_d  = make_header(headerMagic, act_index_q);
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    state_d  = S_HEADER;
                end
            end
            S_HEADER: begin
                if (hs) begin
                    tdata_d = word_at(act_data_q, 0);
                    tlast_d = (LAST_CNT == '0);
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (hs) begin
                    if (cnt_q != LAST_CNT) begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        tdata_d = word_at(act_data_q, int'(cnt_q) + 1);
                        tlast_d = ((cnt_q + CNT_W'(1)) == LAST_CNT);
                    end else begin
                        done    = 1'b1;
                        tlast_d = 1'b0;
                        // Pending packet's header goes out on the very next beat.
                        if (pend_valid_q) begin
                            tdata_d = make_header(headerMagic, pend_index_q);
                            state_d = S_HEADER;
                        end else begin
                            tvalid_d = 1'b0;
                            state_d  = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        act_valid_d  = act_valid_q;
        act_index_d  = act_index_q;
        act_data_d   = act_data_q;
        pend_valid_d = pend_valid_q;
        pend_index_d = pend_index_q;
        pend_data_d  = pend_data_q;
        drop         = 1'b0;
        if (done) begin
            if (pend_valid_q) begin
                act_index_d  = pend_index_q;
                act_data_d   = pend_data_q;
                pend_valid_d = 1'b0;
            end else begin
                act_valid_d = 1'b0;
            end
        end
        // Slots are evaluated after this edge's completion has freed one.
        if (packetStrobe) begin
            if (!act_valid_d) begin
                act_valid_d = 1'b1;
                act_index_d = packetIndex;
                act_data_d  = packetData;
            end else if (!pend_valid_d) begin
                pend_valid_d = 1'b1;
                pend_index_d = packetIndex;
                pend_data_d  = packetData;
            end else begin
                drop = 1'b1;
            end
        end
        busy_d        = act_valid_d | pend_valid_d;
        sent_strobe_d = done;
        drop_strobe_d = drop;
        sent_count_d  = done ? sent_count_q + COUNT_WIDTH'(1) : sent_count_q;
        drop_count_d  = (drop && (drop_count_q != '1)) ? drop_count_q + COUNT_WIDTH'(1) : drop_count_q;
    end

    always_ff @(posedge auroraClk) begin
        if (auroraReset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            tdata_q       <= '0;
            act_valid_q   <= 1'b0;
            act_index_q   <= '0;
            act_data_q    <= '0;
            pend_valid_q  <= 1'b0;
            pend_index_q  <= '0;
            pend_data_q   <= '0;
            busy_q        <= 1'b0;
            sent_strobe_q <= 1'b0;
            drop_strobe_q <= 1'b0;
            sent_count_q  <= '0;
            drop_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            tdata_q       <= tdata_d;
            act_valid_q   <= act_valid_d;
            act_index_q   <= act_index_d;
            act_data_q    <= act_data_d;
            pend_valid_q  <= pend_valid_d;
            pend_index_q  <= pend_index_d;
            pend_data_q   <= pend_data_d;
            busy_q        <= busy_d;
            sent_strobe_q <= sent_strobe_d;
            drop_strobe_q <= drop_strobe_d;
            sent_count_q  <= sent_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign TVALID     = tvalid_q;
    assign TLAST      = tlast_q;
    assign TDATA      = tdata_q;
    assign busy       = busy_q;
    assign sentStrobe = sent_strobe_q;
    assign dropStrobe = drop_strobe_q;
    assign sentCount  = sent_count_q;
    assign dropCount  = drop_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_packet_to_axis.sv
// Bench for packet_to_axis: randomized and directed framing, back-to-back,
// drop, reset and counter-boundary scenarios against a packet-queue model.
`timescale 1ns/1ps
module tb_packet_to_axis;

    localparam int NDW = 4;
    localparam int CW  = 4;
    localparam int PW  = 32 * NDW;

    logic          clk = 1'b0;
    logic          auroraReset;
    logic [15:0]   headerMagic;
    logic          packetStrobe;
    logic [4:0]    packetIndex;
    logic [PW-1:0] packetData;
    logic          TVALID;
    logic          TREADY;
    logic          TLAST;
    logic [31:0]   TDATA;
    logic          busy;
    logic          sentStrobe;
    logic          dropStrobe;
    logic [CW-1:0] sentCount;
    logic [CW-1:0] dropCount;
    logic [1:0]    dbg_state;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    packet_to_axis #(
        .MAGIC_WIDTH(16), .MAGIC_START_BIT(16), .INDEX_WIDTH(5), .INDEX_START_BIT(10),
        .NUM_DATA_WORDS(NDW), .COUNT_WIDTH(CW)
    ) dut (
        .auroraClk(clk), .auroraReset(auroraReset), .headerMagic(headerMagic),
        .packetStrobe(packetStrobe), .packetIndex(packetIndex), .packetData(packetData),
        .TVALID(TVALID), .TREADY(TREADY), .TLAST(TLAST), .TDATA(TDATA), .busy(busy),
        .sentStrobe(sentStrobe), .dropStrobe(dropStrobe), .sentCount(sentCount),
        .dropCount(dropCount), .dbg_state(dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    // Accepted packets occupy at most two slots; every accepted packet pushes
    // its expected beats {tlast, data} into exp_q.
    logic [32:0]   exp_q[$];
    int            occ = 0;
    logic [CW-1:0] m_sent = '0;
    logic [CW-1:0] m_drop = '0;
    logic          m_sent_stb = 1'b0;
    logic          m_drop_stb = 1'b0;
    int            exp_tv = 0;
    logic          stalled = 1'b0;

    task automatic push_packet();
        logic [31:0] hdr;
        hdr = (32'(headerMagic) << 16) | (32'(packetIndex) << 10);
        exp_q.push_back({1'b0, hdr});
        for (int j = 0; j < NDW; j++) begin
            exp_q.push_back({(j == NDW - 1), packetData[32*j +: 32]});
        end
    endtask

    initial begin
        logic hs;
        logic done;
        logic had_pending;
        int   occ_after;
        forever begin
            @(negedge clk);
            check("sentStrobe", 32'(sentStrobe), 32'(m_sent_stb));
            check("dropStrobe", 32'(dropStrobe), 32'(m_drop_stb));
            check("sentCount", 32'(sentCount), 32'(m_sent));
            check("dropCount", 32'(dropCount), 32'(m_drop));
            check("busy", 32'(busy), 32'(occ > 0));
            if (exp_tv >= 0) check("tvalid_expected", 32'(TVALID), 32'(exp_tv));
            if (stalled) check("hold_tvalid", 32'(TVALID), 32'd1);
            if (TVALID === 1'b1) begin
                if (exp_q.size() == 0) check("spurious_tvalid", 32'(TVALID), 32'd0);
                else begin
                    check("tdata", TDATA, exp_q[0][31:0]);
                    check("tlast", 32'(TLAST), 32'(exp_q[0][32]));
                end
            end
            if (auroraReset) begin
                exp_q.delete();
                occ        = 0;
                m_sent     = '0;
                m_drop     = '0;
                m_sent_stb = 1'b0;
                m_drop_stb = 1'b0;
                exp_tv     = 0;
                stalled    = 1'b0;
            end else begin
                hs   = TVALID && TREADY;
                done = 1'b0;
                if (hs && exp_q.size() > 0) begin
                    done = exp_q[0][32];
                    void'(exp_q.pop_front());
                end
                had_pending = (occ == 2);
                occ_after   = occ - int'(done);
                m_drop_stb  = 1'b0;
                if (packetStrobe) begin
                    if (occ_after < 2) begin
                        push_packet();
                        occ_after++;
                    end else begin
                        m_drop_stb = 1'b1;
                        if (m_drop != '1) m_drop++;
                    end
                end
                m_sent_stb = done;
                if (done) m_sent++;
                exp_tv  = done ? int'(had_pending) : -1;
                stalled = TVALID && !TREADY;
                occ     = occ_after;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic [4:0] idx, input logic [PW-1:0] data);
        packetIndex  = idx;
        packetData   = data;
        packetStrobe = 1'b1;
        @(posedge clk); #1;
        packetStrobe = 1'b0;
    endtask

    task automatic do_reset();
        auroraReset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        auroraReset = 1'b0;
    endtask

    task automatic drain();
        TREADY = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (occ == 0 && exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_tvalid", 32'(TVALID), 32'd0);
    endtask

    function automatic logic [PW-1:0] rand_data();
        logic [PW-1:0] d;
        for (int j = 0; j < NDW; j++) d[32*j +: 32] = $urandom;
        return d;
    endfunction

    task automatic report();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        report();
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic found;
        auroraReset  = 1'b1;
        TREADY       = 1'b0;
        packetStrobe = 1'b0;
        headerMagic  = 16'hA5A5;
        packetIndex  = '0;
        packetData   = '0;
        repeat (3) @(posedge clk);
        #1;
        auroraReset = 1'b0;

        check("reset_tvalid", 32'(TVALID), 32'd0);
        check("reset_tlast", 32'(TLAST), 32'd0);
        check("reset_tdata", TDATA, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_sentCount", 32'(sentCount), 32'd0);
        check("reset_dropCount", 32'(dropCount), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);

        // Single packet, index 3, continuous ready: exact header and latency.
        TREADY = 1'b1;
        packetIndex  = 5'd3;
        packetData   = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
        packetStrobe = 1'b1;
        @(posedge clk); #1;
        packetStrobe = 1'b0;
        check("latency_early", 32'(TVALID), 32'd0);
        @(posedge clk); #1;
        check("first_header_valid", 32'(TVALID), 32'd1);
        check("first_header", TDATA, 32'hA5A50C00);
        check("first_header_last", 32'(TLAST), 32'd0);
        @(posedge clk); #1;
        check("first_data", TDATA, 32'hDEADBEEF);
        drain();
        check("sent_after_first", 32'(sentCount), 32'd1);

        // Random traffic with 50% ready.
        for (int i = 0; i < 400; i++) begin
            TREADY       = 1'($urandom_range(0, 1));
            packetStrobe = ($urandom_range(0, 3) == 0);
            packetIndex  = 5'($urandom_range(0, 31));
            packetData   = rand_data();
            @(posedge clk); #1;
        end
        packetStrobe = 1'b0;
        drain();

        // Three strobes while stalled: active, pending, drop; then back-to-back.
        do_reset();
        headerMagic = 16'h5A3C;
        TREADY = 1'b0;
        send_req(5'd1, rand_data());
        send_req(5'd2, rand_data());
        send_req(5'd4, rand_data());
        check("triple_drop_count", 32'(dropCount), 32'd1);
        repeat (3) begin @(posedge clk); #1; end
        drain();
        check("triple_sent", 32'(sentCount), 32'd2);

        // Strobe coincident with final beat while pending is full.
        do_reset();
        TREADY = 1'b0;
        send_req(5'd7, rand_data());
        send_req(5'd8, rand_data());
        TREADY = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (TVALID && TLAST) begin found = 1'b1; break; end
        end
        check("coincide_reach_last", 32'(found), 32'd1);
        TREADY = 1'b0;
        @(posedge clk); #1;
        TREADY = 1'b1;
        send_req(5'd9, rand_data());
        drain();
        check("coincide_sent", 32'(sentCount), 32'd3);
        check("coincide_drop", 32'(dropCount), 32'd0);

        // Reset in the middle of a packet.
        TREADY = 1'b1;
        send_req(5'd12, {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0});
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (TVALID && TDATA == 32'hC1C1C1C1) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        check("midreset_reach_beat2", 32'(found), 32'd1);
        auroraReset  = 1'b1;
        packetStrobe = 1'b1;
        @(posedge clk); #1;
        packetStrobe = 1'b0;
        check("midreset_tvalid", 32'(TVALID), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_sent", 32'(sentCount), 32'd0);
        check("midreset_sentStrobe", 32'(sentStrobe), 32'd0);
        auroraReset = 1'b0;
        @(posedge clk); #1;
        check("midreset_ignored_strobe", 32'(busy), 32'd0);
        send_req(5'd13, rand_data());
        drain();
        check("midreset_clean_sent", 32'(sentCount), 32'd1);

        // Drop counter saturation and sent counter wrap.
        TREADY = 1'b0;
        for (int i = 0; i < 20; i++) send_req(5'($urandom_range(0, 31)), rand_data());
        check("drop_saturated", 32'(dropCount), 32'd15);
        drain();
        for (int i = 0; i < 16; i++) begin
            send_req(5'($urandom_range(0, 31)), rand_data());
            drain();
        end
        check("sent_wrapped", 32'(sentCount), 32'd3);
        check("drop_sticks", 32'(dropCount), 32'd15);

        repeat (3) begin @(posedge clk); #1; end
        report();
        $finish;
    end

endmodule
